// File: rtl/ras_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ras_op_scheduler
// Description : Serialises return-address-stack operations from the 2-wide
//               fetch/predecode stage into the single-op-per-cycle RAS port.
//               Up to two push/pop requests per cycle are buffered in an
//               in-order FIFO. One entry is issued per cycle as registered
//               push/pop/addr. Hold freezes issue, and flush discards all
//               queued and incoming ops. A registered stall-event pulse is
//               provided for the CSR performance counters.
// Ports       : clk, rst                  clock, async active-high reset
//               fetch_sched_valid/push/pop per-lane op (lane 0 is older)
//               fetch_sched_addr          per-lane push address, lane 0 low
//               sched_fetch_ready         both lanes can be accepted
//               sched_ras_hold            RAS cannot take an op
//               sched_flush               redirect, drop everything
//               sched_ras_push/pop/addr   registered RAS op
//               sched_occupancy           current FIFO entry count
//               sched_csrf_stall_add      registered stall-event pulse
// Revision    : 1.0 - initial release
// ============================================================================
module ras_op_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  fetch_sched_valid,
    input  logic [1:0]                  fetch_sched_push,
    input  logic [1:0]                  fetch_sched_pop,
    input  logic [2*ADDR_WIDTH-1:0]     fetch_sched_addr,
    output logic                        sched_fetch_ready,
    input  logic                        sched_ras_hold,
    input  logic                        sched_flush,
    output logic                        sched_ras_push,
    output logic                        sched_ras_pop,
    output logic [ADDR_WIDTH-1:0]       sched_ras_addr,
    output logic [$clog2(FIFO_DEPTH):0] sched_occupancy,
    output logic                        sched_csrf_stall_add
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    // FIFO storage. The contents need no reset because the pointers and
    // count alone decide what is valid.
    logic                  r_mem_push [FIFO_DEPTH];
    logic                  r_mem_pop  [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_mem_addr [FIFO_DEPTH];

    logic [c_PTR_W-1:0]    r_head;
    logic [c_PTR_W-1:0]    r_tail;
    logic [c_CNT_W-1:0]    r_count;

    logic                  w_lane0_q;
    logic                  w_lane1_q;
    logic                  w_enq_ok;
    logic                  w_deq;
    logic [1:0]            w_enq_n;
    logic [c_PTR_W-1:0]    w_lane1_slot;
    logic [ADDR_WIDTH-1:0] w_addr0;
    logic [ADDR_WIDTH-1:0] w_addr1;

    assign w_addr0 = fetch_sched_addr[ADDR_WIDTH-1:0];
    assign w_addr1 = fetch_sched_addr[2*ADDR_WIDTH-1:ADDR_WIDTH];

    // A lane carries a real op only if it asks for a push, a pop or both.
    assign w_lane0_q = fetch_sched_valid[0] & (fetch_sched_push[0] | fetch_sched_pop[0]);
    assign w_lane1_q = fetch_sched_valid[1] & (fetch_sched_push[1] | fetch_sched_pop[1]);

    // Ready depends only on the registered count, so fetch never sees a
    // combinational path from its own valids.
    assign sched_fetch_ready = (r_count <= c_CNT_W'(FIFO_DEPTH - 2));

    assign w_enq_ok = sched_fetch_ready & ~sched_flush;
    assign w_enq_n  = w_enq_ok ? (2'(w_lane0_q) + 2'(w_lane1_q)) : 2'd0;
    assign w_deq    = (r_count != '0) & ~sched_ras_hold & ~sched_flush;

    // When lane 0 is empty, lane 1 takes the tail slot itself.
    assign w_lane1_slot = w_lane0_q ? (r_tail + c_PTR_W'(1)) : r_tail;

    assign sched_occupancy = r_count;

    always_ff @(posedge clk) begin
        if (w_enq_ok && w_lane0_q) begin
            r_mem_push[r_tail] <= fetch_sched_push[0];
            r_mem_pop[r_tail]  <= fetch_sched_pop[0];
            r_mem_addr[r_tail] <= w_addr0;
        end
        if (w_enq_ok && w_lane1_q) begin
            r_mem_push[w_lane1_slot] <= fetch_sched_push[1];
            r_mem_pop[w_lane1_slot]  <= fetch_sched_pop[1];
            r_mem_addr[w_lane1_slot] <= w_addr1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head               <= '0;
            r_tail               <= '0;
            r_count              <= '0;
            sched_ras_push       <= 1'b0;
            sched_ras_pop        <= 1'b0;
            sched_ras_addr       <= '0;
            sched_csrf_stall_add <= 1'b0;
        end else begin
            sched_csrf_stall_add <= (|fetch_sched_valid) & ~sched_fetch_ready & ~sched_flush;

            if (sched_flush) begin
                // Discard everything: queue emptied, any issue suppressed.
                r_head         <= r_tail;
                r_count        <= '0;
                sched_ras_push <= 1'b0;
                sched_ras_pop  <= 1'b0;
                sched_ras_addr <= '0;
            end else begin
                r_tail  <= r_tail + c_PTR_W'(w_enq_n);
                r_count <= r_count + c_CNT_W'(w_enq_n) - c_CNT_W'(w_deq);
                if (w_deq) begin
                    r_head         <= r_head + c_PTR_W'(1);
                    sched_ras_push <= r_mem_push[r_head];
                    sched_ras_pop  <= r_mem_pop[r_head];
                    sched_ras_addr <= r_mem_addr[r_head];
                end else begin
                    sched_ras_push <= 1'b0;
                    sched_ras_pop  <= 1'b0;
                    sched_ras_addr <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ras_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ras_op_scheduler
// Description : Directed self-checking bench for ras_op_scheduler using
//               immediate assertions with hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ras_op_scheduler;

    localparam int c_DEPTH = 4;
    localparam int c_AW    = 32;

    logic              clk;
    logic              rst;
    logic [1:0]        valid;
    logic [1:0]        push;
    logic [1:0]        pop;
    logic [2*c_AW-1:0] addr;
    logic              ready;
    logic              hold;
    logic              flush;
    logic              ras_push;
    logic              ras_pop;
    logic [c_AW-1:0]   ras_addr;
    logic [2:0]        occ;
    logic              stall;

    int n_assert = 0;
    int n_fail   = 0;

    ras_op_scheduler #(
        .FIFO_DEPTH (c_DEPTH),
        .ADDR_WIDTH (c_AW)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .fetch_sched_valid    (valid),
        .fetch_sched_push     (push),
        .fetch_sched_pop      (pop),
        .fetch_sched_addr     (addr),
        .sched_fetch_ready    (ready),
        .sched_ras_hold       (hold),
        .sched_flush          (flush),
        .sched_ras_push       (ras_push),
        .sched_ras_pop        (ras_pop),
        .sched_ras_addr       (ras_addr),
        .sched_occupancy      (occ),
        .sched_csrf_stall_add (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check the full RAS output triple plus occupancy.
    task automatic chk_out(input string tag, input logic p, input logic q,
                           input logic [31:0] a, input logic [2:0] o);
        chk({tag, ".push"}, 64'(ras_push), 64'(p));
        chk({tag, ".pop"},  64'(ras_pop),  64'(q));
        chk({tag, ".addr"}, 64'(ras_addr), 64'(a));
        chk({tag, ".occ"},  64'(occ),      64'(o));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] pu, input logic [1:0] po,
                         input logic [31:0] a0, input logic [31:0] a1);
        valid = v;
        push  = pu;
        pop   = po;
        addr  = {a1, a0};
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
    endtask

    initial begin
        rst   = 1'b1;
        hold  = 1'b0;
        flush = 1'b0;
        idle();
        #12;
        chk_out("reset", 1'b0, 1'b0, 32'h0, 3'd0);
        chk("reset.ready", 64'(ready), 64'd1);
        chk("reset.stall", 64'(stall), 64'd0);
        tick();
        rst = 1'b0;

        // Single lane-0 push: queued after one edge, issued after the next.
        drive(2'b01, 2'b01, 2'b00, 32'h1000, 32'h0);
        tick();
        idle();
        chk_out("t1.queued", 1'b0, 1'b0, 32'h0, 3'd1);
        tick();
        chk_out("t1.issue", 1'b1, 1'b0, 32'h1000, 3'd0);
        tick();
        chk_out("t1.after", 1'b0, 1'b0, 32'h0, 3'd0);

        // Two lanes in one cycle issue on consecutive cycles, lane 0 first.
        drive(2'b11, 2'b01, 2'b10, 32'h2000, 32'h0);
        tick();
        idle();
        chk_out("t2.queued", 1'b0, 1'b0, 32'h0, 3'd2);
        tick();
        chk_out("t2.lane0", 1'b1, 1'b0, 32'h2000, 3'd1);
        tick();
        chk_out("t2.lane1", 1'b0, 1'b1, 32'h0, 3'd0);
        tick();
        chk_out("t2.after", 1'b0, 1'b0, 32'h0, 3'd0);

        // Hold while filling to capacity; fetch keeps its ops valid.
        hold = 1'b1;
        drive(2'b11, 2'b11, 2'b00, 32'hA1, 32'hA2);
        tick();
        chk_out("t3.fill2", 1'b0, 1'b0, 32'h0, 3'd2);
        chk("t3.ready2", 64'(ready), 64'd1);
        drive(2'b11, 2'b01, 2'b10, 32'hA3, 32'h0);
        tick();
        chk_out("t3.fill4", 1'b0, 1'b0, 32'h0, 3'd4);
        chk("t3.ready4", 64'(ready), 64'd0);
        chk("t3.stall_first", 64'(stall), 64'd0);
        drive(2'b11, 2'b11, 2'b00, 32'hA5, 32'hA6);
        tick();
        chk("t3.stall", 64'(stall), 64'd1);
        chk("t3.occ_full", 64'(occ), 64'd4);
        tick();
        chk("t3.stall_again", 64'(stall), 64'd1);
        hold = 1'b0;
        idle();
        tick();
        chk_out("t3.i1", 1'b1, 1'b0, 32'hA1, 3'd3);
        chk("t3.ready3", 64'(ready), 64'd0);
        chk("t3.stall_off", 64'(stall), 64'd0);
        tick();
        chk_out("t3.i2", 1'b1, 1'b0, 32'hA2, 3'd2);
        chk("t3.ready_back", 64'(ready), 64'd1);
        tick();
        chk_out("t3.i3", 1'b1, 1'b0, 32'hA3, 3'd1);
        tick();
        chk_out("t3.i4", 1'b0, 1'b1, 32'h0, 3'd0);
        tick();
        chk_out("t3.after", 1'b0, 1'b0, 32'h0, 3'd0);

        // Three queued entries (second batch is lane 1 only), then flush
        // with a new lane-0 push and hold released.
        hold = 1'b1;
        drive(2'b11, 2'b11, 2'b00, 32'hB1, 32'hB2);
        tick();
        drive(2'b10, 2'b10, 2'b00, 32'h5555, 32'hB3);
        tick();
        chk("t4.occ3", 64'(occ), 64'd3);
        hold  = 1'b0;
        flush = 1'b1;
        drive(2'b01, 2'b01, 2'b00, 32'hC0, 32'h0);
        tick();
        flush = 1'b0;
        idle();
        chk_out("t4.flushed", 1'b0, 1'b0, 32'h0, 3'd0);
        chk("t4.ready", 64'(ready), 64'd1);
        tick();
        chk_out("t4.nothing", 1'b0, 1'b0, 32'h0, 3'd0);

        // Push+pop on lane 0 is one entry; lane 1 valid without op is dropped.
        drive(2'b11, 2'b01, 2'b01, 32'h3000, 32'hDEAD);
        tick();
        idle();
        chk_out("t5.queued", 1'b0, 1'b0, 32'h0, 3'd1);
        tick();
        chk_out("t5.issue", 1'b1, 1'b1, 32'h3000, 3'd0);
        tick();
        chk_out("t5.after", 1'b0, 1'b0, 32'h0, 3'd0);

        // Lane 1 alone lands in the tail slot and issues normally.
        drive(2'b10, 2'b10, 2'b00, 32'h5555, 32'h4000);
        tick();
        idle();
        chk_out("t6.queued", 1'b0, 1'b0, 32'h0, 3'd1);
        tick();
        chk_out("t6.issue", 1'b1, 1'b0, 32'h4000, 3'd0);
        tick();
        chk_out("t6.after", 1'b0, 1'b0, 32'h0, 3'd0);

        // Asynchronous reset while an op is on the outputs and 2 remain queued.
        hold = 1'b1;
        drive(2'b11, 2'b11, 2'b00, 32'hD1, 32'hD2);
        tick();
        drive(2'b01, 2'b01, 2'b00, 32'hD3, 32'h0);
        tick();
        hold = 1'b0;
        idle();
        tick();
        chk_out("t7.issue", 1'b1, 1'b0, 32'hD1, 3'd2);
        #3;
        rst = 1'b1;
        #1;
        chk_out("t7.async", 1'b0, 1'b0, 32'h0, 3'd0);
        chk("t7.ready", 64'(ready), 64'd1);
        tick();
        rst = 1'b0;
        drive(2'b01, 2'b01, 2'b00, 32'h6000, 32'h0);
        tick();
        idle();
        chk_out("t7.requeue", 1'b0, 1'b0, 32'h0, 3'd1);
        tick();
        chk_out("t7.reissue", 1'b1, 1'b0, 32'h6000, 3'd0);
        tick();
        chk_out("t7.after", 1'b0, 1'b0, 32'h0, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ras_op_scheduler.md
Name: ras_op_scheduler

Overview:
Serialises return-address-stack operations from the 2-wide fetch/predecode stage into the single-op-per-cycle RAS port. Buffers up to two push/pop requests per cycle in a small in-order FIFO and issues one per cycle to the RAS as registered push/pop/addr. Supports hold (RAS busy or recovery) and flush (front-end redirect), and emits a stall-event pulse for the CSR performance counters.

Parameters:
FIFO_DEPTH, 4, number of queued ops; power of two, >= 2
ADDR_WIDTH, 32, return-address width; matches `ADDR_WIDTH

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
fetch_sched_valid  input  2  per-lane op valid; lane 0 is older
fetch_sched_push  input  2  per-lane call (push)
fetch_sched_pop  input  2  per-lane return (pop)
fetch_sched_addr  input  2 x ADDR_WIDTH  per-lane push address
sched_fetch_ready  output  1  both lanes can be accepted this cycle
sched_ras_hold  input  1  RAS not ready to take an op
sched_flush  input  1  redirect: discard all queued and incoming ops
sched_ras_push  output  1  registered push to RAS
sched_ras_pop  output  1  registered pop to RAS
sched_ras_addr  output  ADDR_WIDTH  registered address to RAS
sched_occupancy  output  $clog2(FIFO_DEPTH)+1  current FIFO entry count
sched_csrf_stall_add  output  1  registered stall-event pulse

Behaviour:
- Reset (async, rst=1): FIFO empty, head/tail pointers and count = 0, sched_ras_push/pop = 0, sched_ras_addr = 0, sched_csrf_stall_add = 0. sched_fetch_ready = 1 immediately, because the FIFO is empty.
- Entry = {push, pop, addr}. An op with push=pop=0 is invalid; a lane is enqueued only if valid && (push || pop). Push+pop on one lane is kept as a single entry (tail-call/coroutine form).
- sched_fetch_ready = (FIFO_DEPTH - count >= 2); combinational from count only, with no dependence on current-cycle inputs.
- Enqueue: at posedge, if ready && !flush, write qualifying lanes in order (lane 0 first) at tail. If only lane 1 qualifies, it goes to the tail slot. Tail advances by 0/1/2, modulo FIFO_DEPTH.
- When !ready, inputs are ignored. Fetch holds its ops; this is not an error.
- Dequeue/issue: at posedge, if count_before > 0 && !hold && !flush, pop the head entry into the output registers and advance head.
  - Otherwise sched_ras_push/pop <= 0 and sched_ras_addr <= 0.
  - Outputs are valid for exactly one cycle per op. Each FIFO entry is issued exactly once and in order.
- Latency: an op presented at edge N is issued at edge N+1 when the FIFO was empty and hold=0. It is visible on the outputs in the cycle following edge N+1. There is no bypass path.
- Same-cycle enqueue and dequeue are allowed: count_next = count + enq_n - deq_n, with enq_n in {0,1,2} and deq_n in {0,1}. Ready is evaluated on count before the edge.
- Hold: the FIFO keeps its contents and outputs are forced to 0. Enqueue continues while ready.
- Flush has priority over enqueue, dequeue and hold. At the edge: count = 0, head = tail, outputs <= 0, same-cycle inputs discarded. An op issued in the flush cycle is suppressed.
- sched_csrf_stall_add <= (|(fetch_sched_valid) && !sched_fetch_ready && !sched_flush); one pulse per stalled cycle.
- sched_occupancy = count; range 0..FIFO_DEPTH, never exceeds FIFO_DEPTH.
- Reset asserted mid-operation clears all state asynchronously. The first op after reset release issues with the normal latency.

Test Plan:
- Reset, then lane0 push addr=0x1000 (one cycle) -> push=1, addr=0x1000 for exactly one cycle, 2 cycles after input; occupancy 1 then 0.
- Both lanes, cycle 1: lane0 push 0x2000, lane1 pop -> two consecutive cycles: (push, 0x2000), then (pop, addr=0).
- Hold=1; drive 2+2 ops over 2 cycles with FIFO_DEPTH=4 -> occupancy 4, ready=0, stall_add=1 while fetch stays valid. Release hold -> 4 ops issued in order on 4 consecutive cycles; ready returns when count <= 2.
- FIFO holds 3 entries; assert flush together with a new lane0 push -> next cycle occupancy 0, no RAS op issued, the new op is dropped.
- Lane0 push+pop addr=0x3000, lane1 valid with push=pop=0 -> single entry issued with push=1, pop=1, addr=0x3000; lane 1 produces nothing.
- Assert rst asynchronously mid-cycle with 2 entries queued -> outputs are 0 before the next clock edge, occupancy 0, ready=1.
